seq_divider_8bit: RTL

//  Sequential unsigned restoring divider for the 8-bit ULA datapath.
//  - Subtraction side of the adder/subtractor: one trial subtraction per clock.
//  - Sits beside the combinational add/sub/and/or units and gives the ULA a DIV/MOD operation.
//  - Uses a start/busy/done handshake.
//  - Returns quotient, remainder and a divide-by-zero flag.

---
 rtl/seq_divider_8bit.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_divider_8bit.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, quotient/remainder plus divide-by-zero flag.
module seq_divider_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] q;

   logic [WIDTH:0]   r_try;
   logic [WIDTH:0]   t_try;
   logic             q_bit;
   logic [WIDTH-1:0] rem_nxt;
   logic [CW-1:0]    cnt_nxt;

   // dvd shifts left each step, so its MSB is always the next dividend bit
   always_comb begin
      r_try   = {rem, dvd[WIDTH-1]};
      t_try   = r_try - {1'b0, dsr};
      q_bit   = ~t_try[WIDTH];
      rem_nxt = q_bit ? t_try[WIDTH-1:0] : r_try[WIDTH-1:0];
      cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         rem         <= '0;
         q           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            CALC: begin
               rem <= rem_nxt;
               q   <= {q[WIDTH-2:0], q_bit};
               dvd <= {dvd[WIDTH-2:0], 1'b0};
               cnt <= cnt_nxt;
               if (cnt_nxt == CW'(WIDTH)) begin
                  quotient  <= {q[WIDTH-2:0], q_bit};
                  remainder <= rem_nxt;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               // DONE entered with busy still set means a divide-by-zero is pending
               if (busy) begin
                  quotient    <= '1;
                  remainder   <= dvd;
                  div_by_zero <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end else if (start) begin
                  dvd         <= dividend;
                  dsr         <= divisor;
                  rem         <= '0;
                  q           <= '0;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= (divisor == '0) ? DONE : CALC;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
